hazard_ctrl: RTL

- Hazard and pipeline-sequencing controller for the 5-stage RV32 pipeline (F/D/E/M/W).
- Drives every stall, flush and forward select that the datapath currently ties off.
- Keeps its own shadow copy of register-usage info for the instructions in E, M and W, advanced with the stalls and flushes it issues.
- Handles load-use interlock, taken-branch/jump redirect, and a variable-latency data-memory wait handshake with a timeout monitor.

---
 rtl/hazard_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forward-select control for the 5-stage RV32
// pipeline (F/D/E/M/W). It keeps a shadow of the register-usage fields of the
// instructions in E, M and W and advances that shadow with the stalls and
// flushes it issues itself, so the datapath needs no extra hazard tagging.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] RdD,
  input  logic       RegWriteD,
  input  logic       LoadD,
  input  logic       MemAccD,
  input  logic       PCSrcE,
  input  logic       MemReady,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MemTimeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  // Forward select for one E-stage source register. M is younger than W, so
  // it wins. A producer with rd==x0 never reaches here with regWrite set.
  function automatic logic [1:0] fwdSelect(
    input logic [4:0] src,
    input logic       mValid,
    input logic       mRegWrite,
    input logic [4:0] mRd,
    input logic       wValid,
    input logic       wRegWrite,
    input logic [4:0] wRd
  );
    logic [1:0] sel;
    if (mValid && mRegWrite && (mRd == src)) begin
      sel = 2'b10;
    end else if (wValid && wRegWrite && (wRd == src)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  // E-slot shadow
  logic       eValid_r;
  logic [4:0] eRs1_r;
  logic [4:0] eRs2_r;
  logic [4:0] eRd_r;
  logic       eRegWrite_r;
  logic       eLoad_r;
  logic       eMemAcc_r;

  // M-slot shadow
  logic       mValid_r;
  logic [4:0] mRd_r;
  logic       mRegWrite_r;
  logic       mMemAcc_r;

  // W-slot shadow
  logic       wValid_r;
  logic [4:0] wRd_r;
  logic       wRegWrite_r;

  // Memory-wait run counter
  logic [CNT_W-1:0] waitCnt_r;
  logic [CNT_W-1:0] waitCntNext_s;

  logic memWait_s;
  logic loadUse_s;
  logic redirect_s;
  logic dRegWrite_s;

  // Normalise the D-stage write enable: writes to x0 are never real writes,
  // which keeps x0 out of both the interlock and the forwarding compares.
  always_comb begin
    dRegWrite_s = RegWriteD & (RdD != 5'd0);
  end

  // Detect hazards and resolve them in priority order: memory wait freezes
  // everything, a redirect squashes the wrong path (including any load-use it
  // would have caused), and a load-use inserts a single bubble into E.
  always_comb begin
    memWait_s  = mValid_r & mMemAcc_r & ~MemReady;
    loadUse_s  = eValid_r & eLoad_r & eRegWrite_r &
                 ((eRd_r == Rs1D) | (eRd_r == Rs2D));
    redirect_s = PCSrcE;

    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;

    if (memWait_s) begin
      // M cannot retire, so nothing upstream may move; W gets a bubble.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (redirect_s) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (loadUse_s) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else begin
      StallF = 1'b0;
      StallD = 1'b0;
    end
  end

  // Forward selects are independent of stalls: a held E instruction keeps
  // re-evaluating against whatever now sits in M and W.
  always_comb begin
    ForwardAE = fwdSelect(eRs1_r, mValid_r, mRegWrite_r, mRd_r,
                          wValid_r, wRegWrite_r, wRd_r);
    ForwardBE = fwdSelect(eRs2_r, mValid_r, mRegWrite_r, mRd_r,
                          wValid_r, wRegWrite_r, wRd_r);
  end

  // Next wait-counter value: counts consecutive wait cycles, saturating.
  always_comb begin
    if (memWait_s) begin
      if (waitCnt_r == TIMEOUT_CNT) begin
        waitCntNext_s = waitCnt_r;
      end else begin
        waitCntNext_s = waitCnt_r + CNT_ONE;
      end
    end else begin
      waitCntNext_s = {CNT_W{1'b0}};
    end
  end

  // E-slot shadow: bubble on flush, hold on stall, else take the D fields.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      eValid_r    <= 1'b0;
      eRs1_r      <= 5'd0;
      eRs2_r      <= 5'd0;
      eRd_r       <= 5'd0;
      eRegWrite_r <= 1'b0;
      eLoad_r     <= 1'b0;
      eMemAcc_r   <= 1'b0;
    end else if (FlushE) begin
      eValid_r    <= 1'b0;
      eRs1_r      <= 5'd0;
      eRs2_r      <= 5'd0;
      eRd_r       <= 5'd0;
      eRegWrite_r <= 1'b0;
      eLoad_r     <= 1'b0;
      eMemAcc_r   <= 1'b0;
    end else if (!StallE) begin
      eValid_r    <= 1'b1;
      eRs1_r      <= Rs1D;
      eRs2_r      <= Rs2D;
      eRd_r       <= RdD;
      eRegWrite_r <= dRegWrite_s;
      eLoad_r     <= LoadD;
      eMemAcc_r   <= MemAccD;
    end
  end

  // M-slot shadow: there is no M flush, it only holds during a memory wait.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mValid_r    <= 1'b0;
      mRd_r       <= 5'd0;
      mRegWrite_r <= 1'b0;
      mMemAcc_r   <= 1'b0;
    end else if (!StallM) begin
      mValid_r    <= eValid_r;
      mRd_r       <= eRd_r;
      mRegWrite_r <= eRegWrite_r;
      mMemAcc_r   <= eMemAcc_r;
    end
  end

  // W-slot shadow: bubble while M is waiting, otherwise follow M.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wValid_r    <= 1'b0;
      wRd_r       <= 5'd0;
      wRegWrite_r <= 1'b0;
    end else if (FlushW) begin
      wValid_r    <= 1'b0;
      wRd_r       <= 5'd0;
      wRegWrite_r <= 1'b0;
    end else begin
      wValid_r    <= mValid_r;
      wRd_r       <= mRd_r;
      wRegWrite_r <= mRegWrite_r;
    end
  end

  // Wait counter and sticky timeout. The flag rises together with the counter
  // reaching the limit and only reset clears it; it never releases the stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      waitCnt_r  <= {CNT_W{1'b0}};
      MemTimeout <= 1'b0;
    end else begin
      waitCnt_r  <= waitCntNext_s;
      MemTimeout <= MemTimeout | (waitCntNext_s == TIMEOUT_CNT);
    end
  end

endmodule
